// File: rtl/full_adder_pkg.sv
// Shared types and constants for the registered ripple-carry adder.
// The bit-cell result struct and width limit live here.
package full_adder_pkg;

  localparam int MAX_WIDTH = 64;

  typedef struct packed {
    logic carry;
    logic sum;
  } fa_res_t;

  function automatic fa_res_t fa_bit(
    input logic a,
    input logic b,
    input logic cin
  );
    fa_res_t r;
    r.sum   = a ^ b ^ cin;
    r.carry = (a & b) | (a & cin) | (b & cin);
    return r;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder cell.
// Chained by the top level to form the ripple-carry path.
module full_adder_cell
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  fa_res_t res;

  assign res  = fa_bit(a, b, cin);
  assign s    = res.sum;
  assign cout = res.carry;

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {Cout,S} = A + B + Cin, one cycle latency.
// Define FULL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
`ifdef FULL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("full_adder: WIDTH out of range");
  end

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_cell u_cell (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  // Data registers load only on valid, so idle-cycle X never reaches S.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S         <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S    <= sum;
        Cout <= carry[WIDTH];
      end
    end
  end

`ifdef FULL_ADDER_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= carry[WIDTH-1] ^ carry[WIDTH];
    end
  end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH=1 and WIDTH=8.
// Directed steps plus a random back-to-back run.
module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic       s1, co1, ov1_o;
  logic       v8 = 1'b0, c8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [7:0] s8;
  logic       co8, ov8_o;
`ifdef FULL_ADDER_OVF_EN
  logic       ov1, ov8;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
    logic       o;
  } exp_t;

  exp_t q1[$], q8[$];
  exp_t m1 = '{default: '0};
  exp_t m8 = '{default: '0};

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v1),
    .A         (a1),
    .B         (b1),
    .Cin       (c1),
    .S         (s1),
    .Cout      (co1),
`ifdef FULL_ADDER_OVF_EN
    .ovf       (ov1),
`endif
    .out_valid (ov1_o)
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v8),
    .A         (a8),
    .B         (b8),
    .Cin       (c8),
    .S         (s8),
    .Cout      (co8),
`ifdef FULL_ADDER_OVF_EN
    .ovf       (ov8),
`endif
    .out_valid (ov8_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step1(input logic v, input logic a, input logic b,
                       input logic c);
    exp_t e;
    int   sv;
    v1 = v; a1 = a; b1 = b; c1 = c;
    if (v) begin
      {m1.c, m1.s[0]} = 2'(a) + 2'(b) + 2'(c);
      sv   = -int'(a) - int'(b) + int'(c);
      m1.o = (sv < -1) || (sv > 0);
    end
    m1.v = v;
    q1.push_back(m1);
    @(posedge clk); #1;
    e = q1.pop_front();
    chk("w1_s", 64'(s1), 64'(e.s[0]));
    chk("w1_cout", 64'(co1), 64'(e.c));
    chk("w1_valid", 64'(ov1_o), 64'(e.v));
`ifdef FULL_ADDER_OVF_EN
    chk("w1_ovf", 64'(ov1), 64'(e.o));
`endif
  endtask

  task automatic step8(input logic v, input logic [7:0] a,
                       input logic [7:0] b, input logic c);
    exp_t e;
    int   sv;
    v8 = v; a8 = a; b8 = b; c8 = c;
    if (v) begin
      {m8.c, m8.s} = 9'(a) + 9'(b) + 9'(c);
      sv   = int'($signed(a)) + int'($signed(b)) + int'(c);
      m8.o = (sv < -128) || (sv > 127);
    end
    m8.v = v;
    q8.push_back(m8);
    @(posedge clk); #1;
    e = q8.pop_front();
    chk("w8_s", 64'(s8), 64'(e.s));
    chk("w8_cout", 64'(co8), 64'(e.c));
    chk("w8_valid", 64'(ov8_o), 64'(e.v));
`ifdef FULL_ADDER_OVF_EN
    chk("w8_ovf", 64'(ov8), 64'(e.o));
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_s1"}, 64'({s1, co1, ov1_o}), 64'd0);
    chk({tag, "_s8"}, 64'({s8, co8, ov8_o}), 64'd0);
  endtask

  initial begin
    #2;
    chk_zero("reset");
    @(posedge clk); #1;
    chk_zero("reset_held");
    rst = 1'b0;

    step1(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] t;
      t = 3'(i);
      step1(1'b1, t[2], t[1], t[0]);
    end
    step1(1'b0, 1'b0, 1'b1, 1'b0);
    step1(1'b0, 1'b1, 1'b1, 1'b1);

    step8(1'b1, 8'hFF, 8'h00, 1'b1);
    step8(1'b1, 8'h7F, 8'h01, 1'b0);
    chk("s_80", 64'(s8), 64'h80);

    step8(1'b1, 8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 3; i++)
      step8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    chk("hold_46", 64'(s8), 64'h46);
    step8(1'b0, 8'bx, 8'bx, 1'bx);

    step8(1'b1, 8'hFF, 8'hFF, 1'b1);
    chk("pre_rst", 64'({co8, s8}), 64'h1FF);
    #3;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    m1 = '{default: '0};
    m8 = '{default: '0};
    v8 = 1'b1; a8 = 8'h55; b8 = 8'h22; c8 = 1'b1;
    @(posedge clk); #1;
    chk_zero("rst_hold");
    rst = 1'b0;
    step8(1'b0, 8'h01, 8'h02, 1'b0);
    step8(1'b1, 8'h80, 8'h80, 1'b0);

    for (int i = 0; i < 1000; i++)
      step8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
